// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, inverse S-box table and state/flat conversion helpers.
package aes_pkg;

  // state[r][c] is one byte; row-major indexing over a column-major byte map
  typedef logic [3:0][3:0][7:0] state_t;

  localparam logic MODE_FIRST = 1'b0;
  localparam logic MODE_FINAL = 1'b1;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // flat byte k = bits [127-8k -: 8], state[r][c] = byte 4c+r
  function automatic state_t to_matrix(input logic [127:0] flat);
    state_t m;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        m[r][c] = flat[127 - 8 * (4 * c + r) -: 8];
      end
    end
    return m;
  endfunction

  function automatic logic [127:0] to_flat(input state_t m);
    logic [127:0] flat;
    flat = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        flat[127 - 8 * (4 * c + r) -: 8] = m[r][c];
      end
    end
    return flat;
  endfunction

endpackage

// File: rtl/aes_dec_boundary_round_if.sv
// Request/result bundle of the decryption boundary-round engine.
interface aes_dec_boundary_round_if;
  logic         in_valid;
  logic         mode;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic [127:0] state_out;

  modport master (
    output in_valid, mode, state_in, round_key,
    input  out_valid, state_out
  );

  modport slave (
    input  in_valid, mode, state_in, round_key,
    output out_valid, state_out
  );
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);
  assign result = INV_SBOX[value];
endmodule

// File: rtl/aes_dec_boundary_round.sv
// AES-128 decryption head/tail round: ARK (+ InvShiftRows + InvSubBytes in FIRST mode), one register stage.
module aes_dec_boundary_round
  import aes_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  aes_dec_boundary_round_if.slave   bus
);

  state_t       s, k, t, u, v;
  logic [127:0] result;
  logic         out_valid;
  logic [127:0] state_out;

  assign s = to_matrix(bus.state_in);
  assign k = to_matrix(bus.round_key);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign t[r][c] = s[r][c] ^ k[r][c];
      // row r rotated right by r: column c takes column (c - r) mod 4
      assign u[r][c] = t[r][(c + 4 - r) % 4];
      aes_inv_sbox u_sbox (
        .value  (u[r][c]),
        .result (v[r][c])
      );
    end
  end

  assign result = (bus.mode == MODE_FINAL) ? to_flat(t) : to_flat(v);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      state_out <= '0;
    end else begin
      out_valid <= bus.in_valid;
      if (bus.in_valid) state_out <= result;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.state_out = state_out;

endmodule

// File: tb/tb_aes_dec_boundary_round.sv
// Self-checking bench: scoreboard of expected results, independent GF(2^8)-derived S-box model.
module tb_aes_dec_boundary_round;

  logic clk;
  logic rst;
  aes_dec_boundary_round_if bus ();

  aes_dec_boundary_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;
  logic [127:0] exp_q[$];
  logic [127:0] last_out;
  logic [7:0]   fsb [256];
  logic [7:0]   isb [256];

  localparam logic [127:0] FIRST_IN  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] FIRST_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIRST_EXP = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] FINAL_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FINAL_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FINAL_EXP = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // forward S-box from GF inverse + affine map, then inverted
  task automatic build_sbox();
    logic [7:0] inv, x8;
    for (int unsigned x = 0; x < 256; x++) begin
      x8  = x[7:0];
      inv = '0;
      for (int unsigned y = 1; y < 256; y++)
        if (gmul(x8, y[7:0]) == 8'h01) inv = y[7:0];
      fsb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int unsigned x = 0; x < 256; x++) isb[fsb[x]] = x[7:0];
  endtask

  function automatic logic [127:0] model(input logic m, input logic [127:0] s, input logic [127:0] k);
    logic [127:0] t, res;
    int unsigned  src;
    t = s ^ k;
    if (m) return t;
    res = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++) begin
        src = 4 * ((c + 4 - r) % 4) + r;
        res[127 - 8 * (4 * c + r) -: 8] = isb[t[127 - 8 * src -: 8]];
      end
    return res;
  endfunction

  // drive one cycle of inputs at negedge, check outputs at the following negedge
  task automatic cycle(input logic r, input logic v, input logic m,
                       input logic [127:0] s, input logic [127:0] k,
                       input logic [127:0] exp, input string tag);
    logic [127:0] e;
    rst           = r;
    bus.in_valid  = v;
    bus.mode      = m;
    bus.state_in  = s;
    bus.round_key = k;
    if (v && !r) exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {127'b0, bus.out_valid}, {127'b0, v && !r});
    if (r) begin
      check({tag, "_rst"}, bus.state_out, '0);
      last_out = '0;
      exp_q.delete();
    end else if (v) begin
      if (exp_q.size() == 0) begin
        check({tag, "_empty_q"}, 128'h1, 128'h0);
      end else begin
        e = exp_q.pop_front();
        check(tag, bus.state_out, e);
        last_out = e;
      end
    end else begin
      check({tag, "_hold"}, bus.state_out, last_out);
    end
  endtask

  initial begin
    logic [127:0] s, k, e;
    logic         m;
    checks        = 0;
    errors        = 0;
    last_out      = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.state_in  = '0;
    bus.round_key = '0;
    build_sbox();
    @(negedge clk);

    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, "reset");
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, "idle0");

    cycle(1'b0, 1'b1, 1'b0, FIRST_IN, FIRST_KEY, FIRST_EXP, "fips_first");
    cycle(1'b0, 1'b1, 1'b1, FINAL_IN, FINAL_KEY, FINAL_EXP, "fips_final");
    cycle(1'b0, 1'b1, 1'b0, '0, '0, {16{8'h52}}, "sbox_zero");
    s = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b0, 1'b1, 1'b0, s, s, {16{8'h52}}, "sbox_equal");
    cycle(1'b0, 1'b1, 1'b0, {16{8'h63}}, '0, '0, "sbox_63");

    // S-box-premapped byte index pattern exposes the raw shift/byte map
    s = '0;
    e = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++) begin
        s[127 - 8 * (4 * c + r) -: 8] = fsb[4 * c + r];
        e[127 - 8 * (4 * c + r) -: 8] = 8'(4 * ((c + 4 - r) % 4) + r);
      end
    cycle(1'b0, 1'b1, 1'b0, s, '0, e, "byte_map");
    cycle(1'b0, 1'b0, 1'b1, FINAL_IN, FINAL_KEY, '0, "idle1");

    for (int unsigned i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, FIRST_IN, FIRST_KEY, FIRST_EXP, "b2b_first");
      cycle(1'b0, 1'b1, 1'b1, FINAL_IN, FINAL_KEY, FINAL_EXP, "b2b_final");
    end

    cycle(1'b1, 1'b1, 1'b1, FINAL_IN, FINAL_KEY, FINAL_EXP, "rst_with_valid");
    cycle(1'b0, 1'b1, 1'b1, FINAL_IN, FINAL_KEY, FINAL_EXP, "after_rst");

    for (int unsigned i = 0; i < 12; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      cycle(1'b0, 1'b1, m, s, k, model(m, s, k), m ? "rand_final" : "rand_first");
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, "idle2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
